// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word memory slave (clk/rst_n, enable/wr/addr/data request in; q data, state done pulse, busy out)
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic [31:0] q,
  output logic        state,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BSY  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0]        st;
  logic [7:0]        cnt;
  logic [ADDR_W-1:0] idx;
  logic              w;
  logic [31:0]       d;
  logic [31:0]       mem [2**ADDR_W] = '{default: '0};
  logic              accept;
  logic              access;
  logic              unused_hi;
  assign unused_hi = ^addr[31:ADDR_W];
  assign accept    = enable && (st == IDLE || st == RESP);
  assign access    = st == BSY && cnt == 8'd0;
  assign state     = st == RESP;
  assign busy      = st == BSY;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= IDLE;
      q   <= '0;
      cnt <= '0;
    end else if (accept) begin
      idx <= addr[ADDR_W-1:0];
      w   <= wr;
      d   <= data;
      cnt <= 8'(LATENCY - 1);
      st  <= BSY;
    end else if (access) begin
      q  <= w ? d : mem[idx];
      st <= RESP;
    end else if (st == BSY) begin
      cnt <= cnt - 8'd1;
    end else begin
      st <= IDLE;
    end
  end
  always_ff @(posedge clk)
    if (rst_n && access && w) mem[idx] <= d;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven scoreboard bench for mem_responder at LATENCY 4 and 1
module tb_mem_responder;
  localparam int L = 4;
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_q;
    string       name;
  } vec_t;
  typedef struct {
    logic [31:0] q;
    int          t;
    string       name;
  } sb_t;
  logic        clk = 0, rst_n = 0;
  logic        enable = 0, wr = 0;
  logic [31:0] addr = 0, data = 0, q;
  logic        state, busy;
  logic        en1 = 0, wr1 = 0;
  logic [31:0] a1 = 0, d1 = 0, q1;
  logic        st1, bz1;
  int          checks = 0, errors = 0, cyc = 0, pulses = 0;
  sb_t         sb[$];
  sb_t         m_e;
  vec_t        tbl[12];
  mem_responder #(.ADDR_W(8), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr), .data(data),
    .q(q), .state(state), .busy(busy));
  mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .wr(wr1), .addr(a1), .data(d1),
    .q(q1), .state(st1), .busy(bz1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && state) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got state=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        m_e = sb.pop_front();
        chk({m_e.name, "_q"}, q, m_e.q);
        chk({m_e.name, "_latency"}, 32'(cyc), 32'(m_e.t + L));
      end
    end
  end
  task automatic req(input bit w, input logic [31:0] a, input logic [31:0] dt,
                     input logic [31:0] e, input string name);
    int n = 0;
    @(posedge clk) #1;
    while (busy && n < 100) begin
      @(posedge clk) #1;
      n++;
    end
    if (busy) begin
      chk({name, "_accept_timeout"}, 32'(busy), 32'd0);
      return;
    end
    enable = 1; wr = w; addr = a; data = dt;
    @(posedge clk) #1;
    sb.push_back('{q: e, t: cyc, name: name});
    enable = 0; addr = $urandom; data = $urandom; wr = $urandom;
  endtask
  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(posedge clk) #1;
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk) #1;
  endtask
  task automatic lat1(input bit w, input logic [31:0] a, input logic [31:0] dt,
                      input logic [31:0] e, input string name);
    int t;
    @(posedge clk) #1;
    en1 = 1; wr1 = w; a1 = a; d1 = dt;
    @(posedge clk) #1;
    t = cyc;
    en1 = 0; a1 = $urandom; d1 = $urandom;
    @(negedge clk);
    chk({name, "_T_busy_state"}, {30'd0, bz1, st1}, 32'b10);
    @(negedge clk);
    chk({name, "_T1_busy_state"}, {30'd0, bz1, st1}, 32'b01);
    chk({name, "_T1_q"}, q1, e);
    chk({name, "_T1_cycle"}, 32'(cyc), 32'(t + 1));
    @(negedge clk);
    chk({name, "_T2_busy_state"}, {30'd0, bz1, st1}, 32'b00);
  endtask
  initial begin
    int k;
    tbl[0]  = '{1, 32'h05,  32'hDEADBEEF, 32'hDEADBEEF, "wr_5"};
    tbl[1]  = '{0, 32'h05,  32'h0,        32'hDEADBEEF, "rd_5"};
    tbl[2]  = '{1, 32'h105, 32'h12345678, 32'h12345678, "wr_105"};
    tbl[3]  = '{0, 32'h005, 32'hFFFF0000, 32'h12345678, "rd_wrap"};
    tbl[4]  = '{1, 32'h01,  32'hA1,       32'hA1,       "wr_1"};
    tbl[5]  = '{1, 32'h02,  32'hA2,       32'hA2,       "wr_2"};
    tbl[6]  = '{1, 32'h03,  32'hA3,       32'hA3,       "wr_3"};
    tbl[7]  = '{1, 32'h07,  32'h77,       32'h77,       "wr_7"};
    tbl[8]  = '{0, 32'h00,  32'h0,        32'h0,        "rd_0_init"};
    tbl[9]  = '{1, 32'hFFFFFFFF, 32'h5A5A5A5A, 32'h5A5A5A5A, "wr_top"};
    tbl[10] = '{0, 32'h000000FF, 32'h0,   32'h5A5A5A5A, "rd_top"};
    tbl[11] = '{0, 32'h03,  32'h0,        32'hA3,       "rd_3"};
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_after_reset", {q[29:0], busy, state}, 32'd0);
    end
    for (int i = 0; i < 12; i++) req(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].exp_q, tbl[i].name);
    drain();
    k = pulses;
    @(posedge clk) #1;
    for (int n = 0; n < 100; n++) begin
      if (!busy) begin
        if (k == pulses + 3) break;
        enable = 1; wr = 0; addr = 32'(k - pulses + 1);
        sb.push_back('{q: 32'hA0 + 32'(k - pulses + 1), t: cyc + 1, name: "b2b"});
        k++;
      end else begin
        addr = $urandom; wr = $urandom;
      end
      @(posedge clk) #1;
    end
    enable = 0;
    drain();
    chk("b2b_pulse_count", 32'(pulses), 32'(k));
    enable = 1; wr = 1; addr = 7; data = 32'hFFFFFFFF;
    @(posedge clk) #1;
    enable = 0;
    @(posedge clk) #1;
    rst_n = 0;
    @(posedge clk) #1;
    rst_n = 1;
    chk("rst_busy_outputs", {q[29:0], busy, state}, 32'd0);
    k = pulses;
    repeat (L + 4) @(posedge clk);
    chk("rst_busy_no_pulse", 32'(pulses), 32'(k));
    req(0, 32'h07, 32'h0, 32'h77, "rd_7_after_rst");
    drain();
    lat1(1, 32'h09, 32'hCAFE0001, 32'hCAFE0001, "l1_wr");
    lat1(0, 32'h09, 32'h0, 32'hCAFE0001, "l1_rd");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
